// File: rtl/logicap_pkg.sv
// ---------------------------------------------------------------------------
// logicap_pkg: shared types/constants for the capture engine. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package logicap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ABORT     = 3'd4
  } state_e;

  localparam int SYNC_STAGES = 2;

endpackage

`default_nettype wire

// File: rtl/capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// capture_sequencer_if: arm/abort controls and status flags of the capture core. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface capture_sequencer_if;

  logic cap_arm;
  logic cap_abort;
  logic cap_armed;
  logic cap_triggered;
  logic cap_done;
  logic cap_overrun;

  modport master (
    output cap_arm,
    output cap_abort,
    input  cap_armed,
    input  cap_triggered,
    input  cap_done,
    input  cap_overrun
  );

  modport slave (
    input  cap_arm,
    input  cap_abort,
    output cap_armed,
    output cap_triggered,
    output cap_done,
    output cap_overrun
  );

endinterface

`default_nettype wire

// File: rtl/flag_sync.sv
// ---------------------------------------------------------------------------
// flag_sync: multi-bit flop-chain synchronizer for independent level flags. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flag_sync
  import logicap_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/capture_sequencer.sv
// ---------------------------------------------------------------------------
// capture_sequencer: arms the capture core, waits for trigger/done, repeats runs. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module capture_sequencer
  import logicap_pkg::*;
#(
  parameter int RUNS_W     = 8,
  parameter int TMO_W      = 32,
  parameter int ABORT_HOLD = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                repeat_en_i,
  input  logic [RUNS_W-1:0]   run_count_i,
  input  logic [TMO_W-1:0]    timeout_cycles_i,
  capture_sequencer_if.master cap,
  output logic                busy_o,
  output logic [2:0]          state_o,
  output logic [RUNS_W-1:0]   runs_done_o,
  output logic                err_timeout_o,
  output logic                err_overrun_o,
  output logic                irq_o
);

  localparam int AB_W = $clog2(ABORT_HOLD + 1);

  logic [3:0] w_sync;
  logic       s_armed, s_trig, s_done, s_ovr;

  flag_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   ({cap.cap_overrun, cap.cap_done, cap.cap_triggered, cap.cap_armed}),
    .q_o   (w_sync)
  );

  assign {s_ovr, s_done, s_trig, s_armed} = w_sync;

  state_e            state_q;
  logic              arm_q, abort_q, busy_q, irq_q, tmo_err_q, ovr_err_q, rep_q;
  logic [RUNS_W-1:0] runs_q, cnt_q;
  logic [TMO_W-1:0]  tmo_lat_q, tmo_q;
  logic [AB_W-1:0]   ab_q;

  logic [RUNS_W-1:0] w_runs_inc, w_eff_count;
  logic              w_tmo_hit, w_more_runs;

  assign w_runs_inc  = (runs_q == '1) ? runs_q : runs_q + RUNS_W'(1);
  assign w_eff_count = (cnt_q == '0) ? RUNS_W'(1) : cnt_q;
  assign w_more_runs = rep_q && (w_runs_inc < w_eff_count);
  // Counter runs from 0 on entry, so hitting limit-1 means 'timeout_cycles' cycles spent.
  assign w_tmo_hit   = (tmo_lat_q != '0) && (tmo_q == tmo_lat_q - TMO_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      irq_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
      rep_q     <= 1'b0;
      runs_q    <= '0;
      cnt_q     <= '0;
      tmo_lat_q <= '0;
      tmo_q     <= '0;
      ab_q      <= '0;
    end else begin
      irq_q <= 1'b0;
      if ((state_q == ST_WAIT_TRIG || state_q == ST_WAIT_DONE) && s_ovr) ovr_err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            rep_q     <= repeat_en_i;
            cnt_q     <= run_count_i;
            tmo_lat_q <= timeout_cycles_i;
            runs_q    <= '0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
            arm_q     <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (stop_i) begin
            arm_q   <= 1'b0;
            abort_q <= 1'b1;
            ab_q    <= '0;
            state_q <= ST_ABORT;
          end else if (s_armed) begin
            arm_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (stop_i) begin
            abort_q <= 1'b1;
            ab_q    <= '0;
            state_q <= ST_ABORT;
          end else if (s_trig && !s_armed) begin
            state_q <= ST_WAIT_DONE;
          end else if (w_tmo_hit) begin
            tmo_err_q <= 1'b1;
            abort_q   <= 1'b1;
            ab_q      <= '0;
            state_q   <= ST_ABORT;
          end
        end
        ST_WAIT_DONE: begin
          if (s_done) begin
            runs_q <= w_runs_inc;
            if (w_more_runs && stop_i) begin
              // Done beats stop; the run counts, but no re-arm happens.
              abort_q <= 1'b1;
              ab_q    <= '0;
              state_q <= ST_ABORT;
            end else if (w_more_runs) begin
              arm_q   <= 1'b1;
              state_q <= ST_ARM;
            end else begin
              busy_q  <= 1'b0;
              irq_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (stop_i) begin
            abort_q <= 1'b1;
            ab_q    <= '0;
            state_q <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (ab_q == AB_W'(ABORT_HOLD - 1)) begin
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            irq_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            ab_q <= ab_q + AB_W'(1);
          end
        end
        default: begin
          arm_q   <= 1'b0;
          abort_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cap.cap_arm   = arm_q;
  assign cap.cap_abort = abort_q;
  assign busy_o        = busy_q;
  assign state_o       = state_q;
  assign runs_done_o   = runs_q;
  assign err_timeout_o = tmo_err_q;
  assign err_overrun_o = ovr_err_q;
  assign irq_o         = irq_q;

endmodule

`default_nettype wire

// File: doc/capture_sequencer.md
# capture_sequencer

Run controller for the logic-analyzer capture engine, in the system `clk` domain. It arms the capture core, waits for trigger and completion, and repeats for a programmed number of runs. It also enforces an optional trigger timeout, aborts on request, and reports status and a completion interrupt to the register block. All capture-side flags are resynchronized internally, because the capture core runs on the divided sample clock.

## Interface
- `RUNS_W`, 8: width of run count and runs-done counter.
- `TMO_W`, 32: width of trigger-timeout counter.
- `ABORT_HOLD`, 64: `clk` cycles `cap_abort` is held, covering the slowest sample clock.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle start request.
- `stop` in 1: one-cycle stop request.
- `repeat_en` in 1: 0 = single run; 1 = `run_count` runs.
- `run_count` in `RUNS_W`: runs per session; 0 is treated as 1.
- `timeout_cycles` in `TMO_W`: `clk` cycles allowed in WAIT_TRIG; 0 disables the timeout.
- `cap_armed`, `cap_triggered`, `cap_done`, `cap_overrun` in 1 each: capture-core flags, asynchronous to `clk`.
- `cap_arm` out 1: arm level to the capture core.
- `cap_abort` out 1: abort level to the capture core.
- `busy` out 1: state is not IDLE.
- `state` out 3: current FSM encoding.
- `runs_done` out `RUNS_W`: runs completed in this session.
- `err_timeout` out 1: sticky; cleared on the next accepted start.
- `err_overrun` out 1: sticky; cleared on the next accepted start.
- `irq` out 1: one-cycle pulse at session end.

## Operation
- Each `cap_*` input passes through a 2-flop synchronizer. The synced flags are `s_armed`, `s_trig`, `s_done` and `s_ovr`.
- State encodings: IDLE=0, ARM=1, WAIT_TRIG=2, WAIT_DONE=3, ABORT=4.
- IDLE:
  - `start` latches `repeat_en`, `run_count` and `timeout_cycles`.
  - It clears `runs_done`, `err_timeout` and `err_overrun`, then moves to ARM.
  - `stop` is ignored in IDLE.
- ARM:
  - `cap_arm`=1 for the whole state. It is a level, because the core samples it on the slow clock.
  - Exit to WAIT_TRIG when `s_armed`=1.
- WAIT_TRIG:
  - `cap_arm`=0. The timeout counter loads 0 on entry and increments each cycle.
  - `s_trig`=1 and `s_armed`=0 together move the FSM to WAIT_DONE.
  - If the counter reaches `timeout_cycles` (when nonzero), set `err_timeout` and go to ABORT.
  - Trigger and timeout in the same cycle: the trigger wins.
- WAIT_DONE:
  - `s_done`=1 increments `runs_done`.
  - If `repeat_en` is set and the incremented value is below the effective `run_count`, go to ARM.
  - Otherwise go to IDLE and pulse `irq`.
- ABORT:
  - `cap_abort`=1 for exactly `ABORT_HOLD` cycles, then go to IDLE and pulse `irq`.
  - `runs_done` is not incremented.
- `stop` in ARM, WAIT_TRIG or WAIT_DONE moves the FSM to ABORT.
  - `stop` and `s_done` in the same WAIT_DONE cycle: the done wins, the run counts, and `stop` is then honoured if the FSM returns to ARM.
  - `stop` in ABORT is ignored.
- `start` while `busy`=1 is ignored.
- `s_ovr`=1 in WAIT_TRIG or WAIT_DONE sets `err_overrun`. It does not abort.
- `runs_done` saturates at all-ones.

## Timing
- Reset values:
  - state=IDLE.
  - `cap_arm`, `cap_abort`, `busy`, `irq`, `err_timeout`, `err_overrun` = 0.
  - `runs_done`=0.
- All outputs are registered.
- `start` at cycle n gives state=ARM and `cap_arm`=1 at n+1.
- Capture flag edge to the FSM reaction: 3 `clk` cycles (2 synchronizer stages plus the state register).
- `stop` at n gives `cap_abort`=1 at n+1. `irq` pulses at n+1+`ABORT_HOLD`, with state=IDLE in the same cycle.
- `irq` is high for exactly one cycle, coincident with the return to IDLE.
- A new `start` is accepted in the cycle after `irq`.
- Reset mid-run: everything returns to reset values in the next cycle, and `cap_abort` is not asserted.

## Structure
- Shared package `logicap_pkg` holds:
  - the state enum with the encodings above;
  - a `SYNC_STAGES`=2 constant.
- Sub-module `flag_sync`: a parameterized-width 2-flop synchronizer, instanced once for the 4 flags.

## Test plan
- Single run: start; model asserts `cap_armed`, then `cap_triggered`, then `cap_done` -> `cap_arm` high from start+1 until `s_armed`; `runs_done`=1; one `irq` pulse; IDLE.
- Repeat: `repeat_en`=1, `run_count`=3 -> 3 ARM phases, `runs_done`=3, a single `irq` at the end. `run_count`=0 -> exactly 1 run.
- Timeout: `timeout_cycles`=100 with no trigger -> `err_timeout`=1 100 cycles after WAIT_TRIG entry; `cap_abort` high for 64 cycles; `irq`; `runs_done`=0.
- Stop during WAIT_DONE -> ABORT next cycle. Stop coincident with `s_done` on the last run -> normal completion, `runs_done` incremented, `cap_abort` never asserted.
- Overrun: `cap_overrun` pulsed during WAIT_DONE -> `err_overrun` sticky through completion, cleared by the next start. `start` while busy is ignored.
- Reset asserted in WAIT_TRIG -> all outputs at reset values next cycle; a subsequent start runs normally.
